// File: rtl/alu_pkg.sv
// Shared constants for the ALU control unit: opcodes, condition codes and
// flag bit positions within the {N,Z,C,V} flags vector.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_XOR  = 4'd5,
        OP_MOVI = 4'd6,
        OP_MOV  = 4'd7,
        OP_CMP  = 4'd8,
        OP_LDR  = 4'd9
    } opcode_e;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_GT = 4'd2,
        COND_LT = 4'd3,
        COND_GE = 4'd4,
        COND_LE = 4'd5,
        COND_HI = 4'd6,
        COND_LS = 4'd7,
        COND_NE = 4'd8
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_control_unit_if.sv
// Decode/register-bank side bus of the ALU control unit. The master drives
// operands and instruction fields; the slave (the ALU) returns result, flags, PC.
interface alu_control_unit_if;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s;
    logic [2:0]  shift;
    logic [15:0] immediate_value;
    logic [31:0] source1;
    logic [31:0] source2;
    // Net type so the ALU can release it to high impedance on undefined opcodes.
    wire  [31:0] result;
    logic [3:0]  flags;
    logic [7:0]  pc_out;

    modport master (
        output cond, opcode, s, shift, immediate_value, source1, source2,
        input  result, flags, pc_out
    );

    modport slave (
        input  cond, opcode, s, shift, immediate_value, source1, source2,
        output result, flags, pc_out
    );
endinterface

// File: rtl/alu_control_unit_pc_counter.sv
// 8-bit program counter: increments on each rising step strobe, wraps at 255,
// cleared asynchronously by an active-high reset.
module pc_counter (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/alu_control_unit.sv
// Combinational 32-bit ALU with nibble-granular right shift of operand 2,
// NZCV flag generation, condition comparator, and an 8-bit program counter.
module alu_control_unit
    import alu_pkg::*;
(
    input logic               pc_trigger,
    input logic               pc_reset,
    alu_control_unit_if.slave bus
);

    logic [31:0]        intermediate_source2;
    logic [31:0]        s1;
    logic [32:0]        sum_ext;
    logic [31:0]        diff;
    logic signed [31:0] s1_sgn;
    logic signed [31:0] s2_sgn;
    logic               add_v;
    logic               sub_c;
    logic               sub_v;
    logic               cond_ok;
    logic [31:0]        alu_res;
    logic [31:0]        flag_src;
    logic               use_diff;
    logic               op_valid;
    logic               c_flag;
    logic               v_flag;
    logic [3:0]         flags_int;
    opcode_e            op;
    cond_e              cnd;

    // Shift amount is in nibbles: shift*4, so 0..28 bits.
    assign intermediate_source2 = bus.source2 >> {bus.shift, 2'b00};

    assign s1     = bus.source1;
    assign s1_sgn = $signed(bus.source1);
    assign s2_sgn = $signed(intermediate_source2);
    assign op     = opcode_e'(bus.opcode);
    assign cnd    = cond_e'(bus.cond);

    assign sum_ext = {1'b0, s1} + {1'b0, intermediate_source2};
    assign diff    = s1 - intermediate_source2;
    assign add_v   = (s1[31] == intermediate_source2[31]) && (sum_ext[31] != s1[31]);
    assign sub_c   = (s1 < intermediate_source2);
    assign sub_v   = (s1[31] != intermediate_source2[31]) && (diff[31] != s1[31]);

    always_comb begin
        cond_ok = 1'b0;
        case (cnd)
            COND_AL: cond_ok = 1'b1;
            COND_EQ: cond_ok = (s1 == intermediate_source2);
            COND_GT: cond_ok = (s1_sgn > s2_sgn);
            COND_LT: cond_ok = (s1_sgn < s2_sgn);
            COND_GE: cond_ok = (s1_sgn >= s2_sgn);
            COND_LE: cond_ok = (s1_sgn <= s2_sgn);
            COND_HI: cond_ok = (s1 > intermediate_source2);
            COND_LS: cond_ok = (s1 <= intermediate_source2);
            COND_NE: cond_ok = (s1 != intermediate_source2);
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_res  = 32'd0;
        use_diff = 1'b0;
        op_valid = 1'b1;
        c_flag   = 1'b0;
        v_flag   = 1'b0;
        case (op)
            OP_ADD, OP_LDR: begin
                alu_res = sum_ext[31:0];
                c_flag  = sum_ext[32];
                v_flag  = add_v;
            end
            OP_SUB: begin
                alu_res  = diff;
                use_diff = 1'b1;
                c_flag   = sub_c;
                v_flag   = sub_v;
            end
            OP_MUL:  alu_res = s1 * intermediate_source2;
            OP_OR:   alu_res = s1 | intermediate_source2;
            OP_AND:  alu_res = s1 & intermediate_source2;
            OP_XOR:  alu_res = s1 ^ intermediate_source2;
            OP_MOVI: alu_res = {16'h0000, bus.immediate_value};
            OP_MOV:  alu_res = intermediate_source2;
            OP_CMP: begin
                // N/Z report the comparison difference, not the 0/1 outcome.
                alu_res  = {31'd0, cond_ok};
                use_diff = 1'b1;
                c_flag   = sub_c;
                v_flag   = sub_v;
            end
            default: op_valid = 1'b0;
        endcase
        flag_src = use_diff ? diff : alu_res;
    end

    always_comb begin
        flags_int = 4'b0000;
        if (bus.s && op_valid) begin
            flags_int[FLAG_N] = flag_src[31];
            flags_int[FLAG_Z] = (flag_src == 32'd0);
            flags_int[FLAG_C] = c_flag;
            flags_int[FLAG_V] = v_flag;
        end
    end

    assign bus.result = op_valid ? alu_res : 32'hzzzz_zzzz;
    assign bus.flags  = flags_int;

    pc_counter u_pc_counter (
        .clk   (pc_trigger),
        .rst   (pc_reset),
        .count (bus.pc_out)
    );

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: table of ALU vectors with hand-derived
// results/flags, followed by program-counter reset and wrap sequences.
module tb_alu_control_unit;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [3:0]  opcode;
        logic [3:0]  cond;
        logic        s;
        logic [2:0]  shift;
        logic [15:0] imm;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        logic        exp_hiz;
    } vec_t;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    vec_t vecs[$];

    alu_control_unit_if bus ();

    alu_control_unit dut (
        .pc_trigger (clk),
        .pc_reset   (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] opc, input logic [3:0] cnd,
                                input logic s, input logic [2:0] sh, input logic [15:0] imm,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] r, input logic [3:0] f, input logic hz);
        vec_t v;
        v.name = name; v.opcode = opc; v.cond = cnd; v.s = s; v.shift = sh; v.imm = imm;
        v.s1 = a; v.s2 = b; v.exp_res = r; v.exp_flags = f; v.exp_hiz = hz;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.opcode          = v.opcode;
        bus.cond            = v.cond;
        bus.s               = v.s;
        bus.shift           = v.shift;
        bus.immediate_value = v.imm;
        bus.source1         = v.s1;
        bus.source2         = v.s2;
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.opcode = 4'd0; bus.cond = 4'd0; bus.s = 1'b0; bus.shift = 3'd0;
        bus.immediate_value = 16'd0; bus.source1 = 32'd0; bus.source2 = 32'd0;

        //                  name        op  cond  s  sh  imm       s1            s2            result        flags   hiz
        vecs.push_back(mk("add_s0",     0,  0,    0, 0, 16'h0,    32'd1,        32'd2,        32'd3,        4'b0000, 0));
        vecs.push_back(mk("sub_eq",     1,  0,    1, 0, 16'h0,    32'h1111,     32'h1111,     32'h0,        4'b0100, 0));
        vecs.push_back(mk("sub_borrow", 1,  0,    1, 0, 16'h0,    32'h0,        32'hFFFF,     32'hFFFF_0001,4'b1010, 0));
        vecs.push_back(mk("sub_ovf",    1,  0,    1, 0, 16'h0,    32'h8000_0000,32'h1,        32'h7FFF_FFFF,4'b0001, 0));
        vecs.push_back(mk("or_shift1",  3,  0,    0, 1, 16'h0,    32'h9,        32'h6,        32'h9,        4'b0000, 0));
        vecs.push_back(mk("mul_5x5",    2,  0,    0, 0, 16'h0,    32'd5,        32'd5,        32'h19,       4'b0000, 0));
        vecs.push_back(mk("mul_trunc",  2,  0,    1, 0, 16'h0,    32'h1_0000,   32'h1_0000,   32'h0,        4'b0100, 0));
        vecs.push_back(mk("movi",       6,  0,    0, 0, 16'hFFFF, 32'h0,        32'h0,        32'h0000_FFFF,4'b0000, 0));
        vecs.push_back(mk("mov",        7,  0,    0, 0, 16'h0,    32'h0,        32'h1111,     32'h1111,     4'b0000, 0));
        vecs.push_back(mk("mov_shift7", 7,  0,    1, 7, 16'h0,    32'h0,        32'hF000_0000,32'hF,        4'b0000, 0));
        vecs.push_back(mk("add_ovf",    0,  0,    1, 0, 16'h0,    32'h7FFF_FFFF,32'h1,        32'h8000_0000,4'b1001, 0));
        vecs.push_back(mk("add_carry",  0,  0,    1, 0, 16'h0,    32'hFFFF_FFFF,32'h1,        32'h0,        4'b0110, 0));
        vecs.push_back(mk("ldr",        9,  0,    1, 0, 16'h0,    32'h10,       32'h20,       32'h30,       4'b0000, 0));
        vecs.push_back(mk("xor_zero",   5,  0,    1, 0, 16'h0,    32'hFFFF_0000,32'hFFFF_0000,32'h0,        4'b0100, 0));
        vecs.push_back(mk("and_neg",    4,  0,    1, 0, 16'h0,    32'hF0F0_F0F0,32'hFF00_FF00,32'hF000_F000,4'b1000, 0));
        vecs.push_back(mk("cmp_eq",     8,  1,    0, 0, 16'h0,    32'h1111,     32'h1111,     32'd1,        4'b0000, 0));
        vecs.push_back(mk("cmp_gt",     8,  2,    0, 0, 16'h0,    32'hF001_1111,32'h1111,     32'd0,        4'b0000, 0));
        vecs.push_back(mk("cmp_hi",     8,  6,    0, 0, 16'h0,    32'h1_1111,   32'h1111,     32'd1,        4'b0000, 0));
        vecs.push_back(mk("cmp_lt_s1",  8,  3,    1, 0, 16'h0,    32'd1,        32'd2,        32'd1,        4'b1010, 0));
        vecs.push_back(mk("cmp_ge",     8,  4,    0, 0, 16'h0,    32'hFFFF_FFFF,32'h0,        32'd0,        4'b0000, 0));
        vecs.push_back(mk("cmp_le",     8,  5,    0, 0, 16'h0,    32'hFFFF_FFFF,32'h0,        32'd1,        4'b0000, 0));
        vecs.push_back(mk("cmp_ls",     8,  7,    0, 0, 16'h0,    32'h1111,     32'h1111,     32'd1,        4'b0000, 0));
        vecs.push_back(mk("cmp_ne",     8,  8,    0, 0, 16'h0,    32'd1,        32'd2,        32'd1,        4'b0000, 0));
        vecs.push_back(mk("cmp_al_s1",  8,  0,    1, 0, 16'h0,    32'h5,        32'h5,        32'd1,        4'b0100, 0));
        vecs.push_back(mk("cmp_badc",   8,  15,   0, 0, 16'h0,    32'd1,        32'd1,        32'd0,        4'b0000, 0));
        vecs.push_back(mk("op15",       15, 0,    1, 0, 16'h0,    32'h7FFF_FFFF,32'h1,        32'h0,        4'b0000, 1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
            if (vecs[i].exp_hiz) begin
                // A two-state simulator resolves an undriven bus to zero; either is a release.
                n_assert++;
                if (!(bus.result === 32'hzzzz_zzzz || bus.result === 32'h0)) begin
                    n_fail++;
                    $display("FAIL %s_res: got %h expected zzzzzzzz", vecs[i].name, bus.result);
                end
            end else begin
                check({vecs[i].name, "_res"}, bus.result, vecs[i].exp_res);
            end
            check({vecs[i].name, "_flags"}, {28'd0, bus.flags}, {28'd0, vecs[i].exp_flags});
        end

        // Shifted operand probe: 4'b0110 >> 4 is zero.
        apply(mk("probe", 3, 0, 0, 1, 16'h0, 32'h9, 32'h6, 32'h9, 4'b0000, 0));
        check("intermediate_s2", dut.intermediate_source2, 32'h0);
        apply(mk("probe2", 7, 0, 0, 2, 16'h0, 32'h0, 32'hABCD_1234, 32'h0, 4'b0000, 0));
        check("intermediate_s2_sh2", dut.intermediate_source2, 32'h00AB_CD12);

        // PC held in reset across edges
        repeat (3) @(posedge clk);
        #1 check("pc_in_reset", {24'd0, bus.pc_out}, 32'd0);
        // Reset must not disturb the combinational path
        apply(mk("add_rst", 0, 0, 1, 0, 16'h0, 32'd1, 32'd2, 32'd3, 4'b0000, 0));
        check("add_during_reset", bus.result, 32'd3);

        @(negedge clk) rst = 1'b0;
        #1 check("pc_after_release", {24'd0, bus.pc_out}, 32'd0);
        @(posedge clk);
        #1 check("pc_first_edge", {24'd0, bus.pc_out}, 32'd1);
        repeat (2) @(posedge clk);
        #1 check("pc_three_edges", {24'd0, bus.pc_out}, 32'd3);

        // Asynchronous clear mid-cycle
        #2 rst = 1'b1;
        #1 check("pc_async_clear", {24'd0, bus.pc_out}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("pc_restart", {24'd0, bus.pc_out}, 32'd1);

        // Reset arriving with a clock edge wins
        @(posedge clk) rst = 1'b1;
        #1 check("pc_reset_at_edge", {24'd0, bus.pc_out}, 32'd0);
        @(posedge clk);
        #1 check("pc_hold_reset", {24'd0, bus.pc_out}, 32'd0);

        // Wrap from 255 to 0
        @(negedge clk) rst = 1'b0;
        repeat (255) @(posedge clk);
        #1 check("pc_255", {24'd0, bus.pc_out}, 32'd255);
        @(posedge clk);
        #1 check("pc_wrap", {24'd0, bus.pc_out}, 32'd0);
        @(posedge clk);
        #1 check("pc_after_wrap", {24'd0, bus.pc_out}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
